vector_sweep_ctrl: RTL

VECTOR_SWEEP_CTRL -- requirements
Module: vector_sweep_ctrl

---
 rtl/vector_sweep_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input sweep of a single-output DUT: applies every vector, captures the response,
// streams a record per vector and compares the captured truth table against a golden one.
module vector_sweep_ctrl #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   CK,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(2**N_IN)-1:0]   golden,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   rec_valid,
    output logic [N_IN-1:0]        rec_vec,
    output logic                   rec_bit,
    input  logic                   rec_ready,
    output logic [(2**N_IN)-1:0]   truth_table,
    output logic [N_IN:0]          mismatch_cnt,
    output logic                   trojan_flag,
    output logic                   done
);

    localparam int unsigned NV = 2**N_IN;
    localparam int unsigned CW = 4;
    localparam int unsigned MW = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_last_settle;
    logic [N_IN-1:0]   r_vec;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_rec_valid;
    logic [N_IN-1:0]   r_rec_vec;
    logic              r_rec_bit;
    logic [NV-1:0]     r_tt;
    logic [MW-1:0]     r_mc;
    logic              r_trojan;
    logic              r_done;

    // State register.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort outranks the record handshake.
    always_comb begin
        w_next        = r_state;
        w_last_settle = (r_cnt == CW'(1));
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)              w_next = S_IDLE;
                else if (w_last_settle) w_next = S_EMIT;
            end
            S_EMIT: begin
                if (abort)          w_next = S_IDLE;
                else if (rec_ready) w_next = (r_vec == LAST_VEC) ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs, decoded from the next state.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_vec       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_rec_valid <= 1'b0;
            r_rec_vec   <= '0;
            r_rec_bit   <= 1'b0;
            r_tt        <= '0;
            r_mc        <= '0;
            r_trojan    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy      <= (w_next == S_SETTLE) || (w_next == S_EMIT);
            r_rec_valid <= (w_next == S_EMIT);
            r_done      <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec    <= '0;
                        r_cnt    <= CW'(SETTLE);
                        r_tt     <= '0;
                        r_mc     <= '0;
                        r_trojan <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_vec <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                        if (w_last_settle) begin
                            r_tt[r_vec] <= dut_out;
                            r_rec_bit   <= dut_out;
                            r_rec_vec   <= r_vec;
                            if (dut_out != golden[r_vec]) r_mc <= r_mc + MW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (abort) begin
                        r_vec <= '0;
                    end else if (rec_ready) begin
                        if (r_vec == LAST_VEC) begin
                            r_trojan <= (r_mc != '0);
                        end else begin
                            r_vec <= r_vec + N_IN'(1);
                            r_cnt <= CW'(SETTLE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in       = r_vec;
    assign busy         = r_busy;
    assign rec_valid    = r_rec_valid;
    assign rec_vec      = r_rec_vec;
    assign rec_bit      = r_rec_bit;
    assign truth_table  = r_tt;
    assign mismatch_cnt = r_mc;
    assign trojan_flag  = r_trojan;
    assign done         = r_done;

endmodule
